sfx_sequencer: RTL and testbench

Parametrised multi-event sound-effect engine. It replaces hard-wired per-effect tone logic with a runtime-loadable step table per event, priority arbitration with preemption, per-step volume, and optional looping. It sits between game logic (event trigger pulses) and the audio pin, and drives one PWM-gated square-wave output.

---
 rtl/sfx_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: multi-event sound-effect engine driving one PWM-gated square-wave pin.
// Each event owns a runtime-loadable step table of {half-period, duration, volume, last}.
// Higher event index preempts lower. Steps play back-to-back with a one-cycle LOAD gap.
// Optional feature: define SFX_LOOP_EN to add per-event loop flags and the cfg_loop port.
module sfx_sequencer #(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned SEQ_DEPTH  = 16,
    parameter int unsigned HP_W       = 20,
    parameter int unsigned DUR_W      = 8,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned TICK_DIV   = 100000,
    localparam int unsigned EV_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
    localparam int unsigned ST_W      = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_EVENTS-1:0] trig,
    input  logic                  stop,
    input  logic                  cfg_we,
    input  logic [EV_W-1:0]       cfg_event,
    input  logic [ST_W-1:0]       cfg_step,
    input  logic [HP_W-1:0]       cfg_hp,
    input  logic [DUR_W-1:0]      cfg_dur,
    input  logic [PWM_W-1:0]      cfg_vol,
    input  logic                  cfg_last,
`ifdef SFX_LOOP_EN
    input  logic                  cfg_loop,
`endif
    output logic                  tone_out,
    output logic                  busy,
    output logic [EV_W-1:0]       active_event,
    output logic                  done,
    output logic                  dropped
);

    localparam int unsigned ADDR_W  = EV_W + ST_W;
    localparam int unsigned ENTRY_W = HP_W + DUR_W + PWM_W + 1;
    localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [ST_W-1:0]  STEP_MAX = ST_W'(SEQ_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_t;

    state_t              state_q;
    logic [EV_W-1:0]     ev_q;
    logic [ST_W-1:0]     step_q;
    logic [HP_W-1:0]     hc_q;
    logic                phase_q;
    logic [PRE_W-1:0]    pre_q;
    logic [DUR_W-1:0]    tk_q;
    logic [PWM_W-1:0]    pc_q;

    logic [ENTRY_W-1:0]  table_mem [1 << ADDR_W];
    logic [ENTRY_W-1:0]  entry_q;

    logic [HP_W-1:0]     cur_hp;
    logic [DUR_W-1:0]    cur_dur;
    logic [PWM_W-1:0]    cur_vol;
    logic                cur_last;
    logic [DUR_W-1:0]    dur_max;
    logic                tick_end;
    logic                step_end;
    logic                seq_end;
    logic                loop_hit;
    logic                trig_any;
    logic                trig_take;
    logic [EV_W-1:0]     trig_win;

    // Step table: synchronous write, read only during LOAD so the working copy stays frozen
    // for the whole step; a same-cycle write to the read address returns the old entry.
    always_ff @(posedge sys_clk) begin
        if (cfg_we) begin
            table_mem[{cfg_event, cfg_step}] <= {cfg_hp, cfg_dur, cfg_vol, cfg_last};
        end
        if (state_q == StLoad) begin
            entry_q <= table_mem[{ev_q, step_q}];
        end
    end

    assign cur_hp   = entry_q[ENTRY_W-1 -: HP_W];
    assign cur_dur  = entry_q[1 + PWM_W +: DUR_W];
    assign cur_vol  = entry_q[1 +: PWM_W];
    assign cur_last = entry_q[0];

`ifdef SFX_LOOP_EN
    logic [NUM_EVENTS-1:0] loop_q;

    // Loop flag of an event follows cfg_loop of the latest table write to that event.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            loop_q <= '0;
        end else if (cfg_we && (32'(cfg_event) < NUM_EVENTS)) begin
            loop_q[cfg_event] <= cfg_loop;
        end
    end

    assign loop_hit = loop_q[ev_q];
`else
    assign loop_hit = 1'b0;
`endif

    // Highest set trigger bit wins; lower bits in the same cycle are discarded.
    always_comb begin
        trig_win = '0;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            if (trig[i]) begin
                trig_win = EV_W'(i);
            end
        end
    end

    assign trig_any  = |trig;
    assign trig_take = trig_any && ((state_q == StIdle) || (trig_win >= ev_q));

    assign dur_max  = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
    assign tick_end = (pre_q == PRE_MAX);
    assign step_end = tick_end && (tk_q == dur_max - DUR_W'(1));
    assign seq_end  = cur_last || (step_q == STEP_MAX);

    // Sequencer FSM with tone, duration and PWM counters and registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
            ev_q    <= '0;
            step_q  <= '0;
            hc_q    <= '0;
            phase_q <= 1'b0;
            pre_q   <= '0;
            tk_q    <= '0;
            pc_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            pc_q    <= pc_q + PWM_W'(1);
            done    <= 1'b0;
            dropped <= 1'b0;
            if (stop) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else if (trig_take) begin
                // Start, preempt or restart: always from step 0 through LOAD.
                ev_q    <= trig_win;
                step_q  <= '0;
                state_q <= StLoad;
                busy    <= 1'b1;
            end else begin
                // Reaching here with a trigger means it lost arbitration.
                dropped <= trig_any;
                unique case (state_q)
                    StIdle: begin
                        busy <= 1'b0;
                    end
                    StLoad: begin
                        state_q <= StPlay;
                        hc_q    <= '0;
                        phase_q <= 1'b1;
                        pre_q   <= '0;
                        tk_q    <= '0;
                    end
                    StPlay: begin
                        pre_q <= tick_end ? '0 : pre_q + PRE_W'(1);
                        if (tick_end) begin
                            tk_q <= tk_q + DUR_W'(1);
                        end
                        if (cur_hp == '0) begin
                            phase_q <= 1'b0;
                            hc_q    <= '0;
                        end else if (hc_q == cur_hp - HP_W'(1)) begin
                            phase_q <= ~phase_q;
                            hc_q    <= '0;
                        end else begin
                            hc_q <= hc_q + HP_W'(1);
                        end
                        if (step_end) begin
                            if (!seq_end) begin
                                step_q  <= step_q + ST_W'(1);
                                state_q <= StLoad;
                            end else if (loop_hit) begin
                                step_q  <= '0;
                                state_q <= StLoad;
                            end else begin
                                state_q <= StIdle;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign active_event = ev_q;

    // Entry into PLAY forces phase high before the new half-period is visible, so a rest
    // step is gated on hp here to stay silent from its very first cycle.
    assign tone_out = (state_q == StPlay) && phase_q && (cur_hp != '0) && (pc_q < cur_vol);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_DIV=4. The loop scenario builds only with
// SFX_LOOP_EN defined.
module tb_sfx_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  trig;
    logic        stop;
    logic        cfg_we;
    logic [1:0]  cfg_event;
    logic [3:0]  cfg_step;
    logic [19:0] cfg_hp;
    logic [7:0]  cfg_dur;
    logic [7:0]  cfg_vol;
    logic        cfg_last;
`ifdef SFX_LOOP_EN
    logic        cfg_loop;
`endif
    logic        tone_out;
    logic        busy;
    logic [1:0]  active_event;
    logic        done;
    logic        dropped;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  tb_pc;

    sfx_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .trig         (trig),
        .stop         (stop),
        .cfg_we       (cfg_we),
        .cfg_event    (cfg_event),
        .cfg_step     (cfg_step),
        .cfg_hp       (cfg_hp),
        .cfg_dur      (cfg_dur),
        .cfg_vol      (cfg_vol),
        .cfg_last     (cfg_last),
`ifdef SFX_LOOP_EN
        .cfg_loop     (cfg_loop),
`endif
        .tone_out     (tone_out),
        .busy         (busy),
        .active_event (active_event),
        .done         (done),
        .dropped      (dropped)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model of the free-running PWM counter (cleared only by reset).
    always @(posedge sys_clk) begin
        if (sys_rst) tb_pc <= 8'd0;
        else         tb_pc <= tb_pc + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ev, input logic [3:0] st, input logic [19:0] hp,
                             input logic [7:0] dur, input logic [7:0] vol, input logic last);
        cfg_we    = 1'b1;
        cfg_event = ev;
        cfg_step  = st;
        cfg_hp    = hp;
        cfg_dur   = dur;
        cfg_vol   = vol;
        cfg_last  = last;
        step_clk();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        trig = m;
        step_clk();
        trig = 4'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tone"},   32'(tone_out),     32'd0);
        check_eq({tag, "_busy"},   32'(busy),         32'd0);
        check_eq({tag, "_active"}, 32'(active_event), 32'd0);
        check_eq({tag, "_done"},   32'(done),         32'd0);
        check_eq({tag, "_drop"},   32'(dropped),      32'd0);
    endtask

    // Starts in the LOAD cycle; pat bit i is the expected square-wave phase in cycle i.
    task automatic play_check(input string tag, input int n, input logic [63:0] pat,
                              input logic [7:0] vol, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_tone"}, 32'(tone_out), 32'(pat[i] & (tb_pc < vol)));
            check_eq({tag, "_busy"}, 32'(busy),     32'd1);
            check_eq({tag, "_done"}, 32'(done),     32'd0);
            check_eq({tag, "_drop"}, 32'(dropped),  32'd0);
            step_clk();
        end
        check_eq({tag, "_end_busy"}, 32'(busy),     32'd0);
        check_eq({tag, "_end_done"}, 32'(done),     32'(exp_done));
        check_eq({tag, "_end_tone"}, 32'(tone_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        sys_rst   = 1'b1;
        trig      = 4'd0;
        stop      = 1'b0;
        cfg_we    = 1'b0;
        cfg_event = 2'd0;
        cfg_step  = 4'd0;
        cfg_hp    = 20'd0;
        cfg_dur   = 8'd0;
        cfg_vol   = 8'd0;
        cfg_last  = 1'b0;
`ifdef SFX_LOOP_EN
        cfg_loop  = 1'b0;
`endif
        repeat (2) step_clk();
        check_reset_vals("rst");
        sys_rst = 1'b0;
        step_clk();

        // 1: single step hp=3 dur=2: LOAD then HHHLLLHH, done as it returns to idle.
        cfg_write(2'd0, 4'd0, 20'd3, 8'd2, 8'd255, 1'b1);
        pulse_trig(4'b0001);
        play_check("t1", 9, 64'b110001110, 8'd255, 1'b1);
        step_clk();
        check_eq("t1_done_width", 32'(done), 32'd0);

        // 2: three steps hp=2 / rest (dur=0 acts as 1) / hp=5 dur=3, LOAD gap between steps.
        cfg_write(2'd0, 4'd0, 20'd2, 8'd1, 8'd255, 1'b0);
        cfg_write(2'd0, 4'd1, 20'd0, 8'd0, 8'd255, 1'b0);
        cfg_write(2'd0, 4'd2, 20'd5, 8'd3, 8'd255, 1'b1);
        pulse_trig(4'b0001);
        play_check("t2", 23, 64'b11000001111100000000110, 8'd255, 1'b1);

        // 3: lower trigger dropped mid-step, higher trigger preempts without done.
        cfg_write(2'd1, 4'd0, 20'd4, 8'd3, 8'd255, 1'b1);
        cfg_write(2'd3, 4'd0, 20'd1, 8'd1, 8'd255, 1'b1);
        pulse_trig(4'b0010);
        check_eq("t3_active1", 32'(active_event), 32'd1);
        repeat (3) step_clk();
        pulse_trig(4'b0001);
        check_eq("t3_dropped", 32'(dropped),      32'd1);
        check_eq("t3_keep_ev", 32'(active_event), 32'd1);
        check_eq("t3_keep_bz", 32'(busy),         32'd1);
        check_eq("t3_keep_hi", 32'(tone_out),     32'(tb_pc < 8'd255));
        step_clk();
        check_eq("t3_drop_1c", 32'(dropped),      32'd0);
        check_eq("t3_keep_lo", 32'(tone_out),     32'd0);
        pulse_trig(4'b1000);
        check_eq("t3_active3", 32'(active_event), 32'd3);
        play_check("t3", 5, 64'b01010, 8'd255, 1'b1);
        step_clk();
        check_eq("t3_no_done1", 32'(done), 32'd0);

        // 4: simultaneous triggers 0 and 2 from idle: event 2 plays, nothing dropped.
        cfg_write(2'd2, 4'd0, 20'd2, 8'd1, 8'd255, 1'b1);
        pulse_trig(4'b0101);
        check_eq("t4_active2", 32'(active_event), 32'd2);
        play_check("t4", 5, 64'b00110, 8'd255, 1'b1);

        // Same-event retrigger restarts from step 0.
        pulse_trig(4'b0100);
        repeat (2) step_clk();
        pulse_trig(4'b0100);
        check_eq("t4r_active", 32'(active_event), 32'd2);
        play_check("t4r", 5, 64'b00110, 8'd255, 1'b1);

        // Volume 0 is silent even while the phase is high.
        cfg_write(2'd1, 4'd0, 20'd1, 8'd1, 8'd0, 1'b1);
        pulse_trig(4'b0010);
        play_check("vol0", 5, 64'b01010, 8'd0, 1'b1);

        // Sequence without any last flag ends after step SEQ_DEPTH-1: 16 x (1 + 4) cycles.
        for (int s = 0; s < 16; s++) cfg_write(2'd3, 4'(s), 20'd0, 8'd1, 8'd0, 1'b0);
        pulse_trig(4'b1000);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step_clk();
        end
        check_eq("depth_len",  32'(cnt),  32'd80);
        check_eq("depth_done", 32'(done), 32'd1);

        // 5: stop alone, then stop + reset + trig together during PLAY.
        pulse_trig(4'b0100);
        step_clk();
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check_eq("t5_stop_busy", 32'(busy),         32'd0);
        check_eq("t5_stop_done", 32'(done),         32'd0);
        check_eq("t5_stop_tone", 32'(tone_out),     32'd0);
        check_eq("t5_stop_ev",   32'(active_event), 32'd2);
        pulse_trig(4'b0100);
        repeat (2) step_clk();
        stop    = 1'b1;
        sys_rst = 1'b1;
        trig    = 4'b1111;
        step_clk();
        stop    = 1'b0;
        sys_rst = 1'b0;
        trig    = 4'd0;
        check_reset_vals("t5_rst");
        pulse_trig(4'b0100);
        play_check("t5_replay", 5, 64'b00110, 8'd255, 1'b1);

`ifdef SFX_LOOP_EN
        // 6: looped two-step event repeats with no done; stop ends it in one cycle.
        cfg_loop = 1'b1;
        cfg_write(2'd1, 4'd0, 20'd1, 8'd1, 8'd255, 1'b0);
        cfg_write(2'd1, 4'd1, 20'd2, 8'd1, 8'd255, 1'b1);
        cfg_loop = 1'b0;
        pulse_trig(4'b0010);
        for (int i = 0; i < 35; i++) begin
            logic [9:0] pat10;
            pat10 = 10'b0011001010;
            check_eq("t6_tone", 32'(tone_out), 32'(pat10[i % 10] & (tb_pc < 8'd255)));
            check_eq("t6_busy", 32'(busy),     32'd1);
            check_eq("t6_done", 32'(done),     32'd0);
            step_clk();
        end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check_eq("t6_stop_busy", 32'(busy), 32'd0);
        check_eq("t6_stop_done", 32'(done), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
